ram_scan_ctrl: RTL and testbench

- Sequencing and arbitration controller for the 32x4 single-port synchronous lab RAM; it is the only master driving the RAM address, data and write-enable.
- After reset it zero-fills the RAM, then arbitrates between a user write requester (switch-driven) and a periodic display scanner.
- The scanner reads one address per tick and presents an atomic {address, data} pair to the seven-segment decode logic.

---
 rtl/ram_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_ctrl.sv
// rtl/ram_scan_ctrl.sv - lab RAM zero-fill, write arbitration and periodic display scan controller
// Optional write readback check is enabled by defining RAM_WR_VERIFY_EN.
module ram_scan_ctrl #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 4,
   parameter int TICK_CYCLES = 50000000,
   parameter int RD_LAT      = 1
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   input  logic              scan_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              init_busy
);

   localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] RD_DONE  = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] VFY_DONE = CNT_W'(RD_LAT + 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [2:0] {
      S_INIT,
      S_INIT_END,
      S_IDLE,
      S_WRITE,
      S_RD_WAIT,
      S_VERIFY
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              scan_pend_q, scan_pend_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic              ram_wren_q, ram_wren_d;
   logic              wr_ack_q, wr_ack_d;
   logic              wr_err_q, wr_err_d;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic              disp_valid_q, disp_valid_d;
   logic              scan_pend_clr;
   logic              tick_active;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         init_cnt_q   <= '0;
         scan_ptr_q   <= '0;
         tick_cnt_q   <= '0;
         scan_pend_q  <= 1'b0;
         rd_cnt_q     <= '0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_wren_q   <= 1'b0;
         wr_ack_q     <= 1'b0;
         wr_err_q     <= 1'b0;
         disp_addr_q  <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         scan_ptr_q   <= scan_ptr_d;
         tick_cnt_q   <= tick_cnt_d;
         scan_pend_q  <= scan_pend_d;
         rd_cnt_q     <= rd_cnt_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         ram_wren_q   <= ram_wren_d;
         wr_ack_q     <= wr_ack_d;
         wr_err_q     <= wr_err_d;
         disp_addr_q  <= disp_addr_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      scan_ptr_d    = scan_ptr_q;
      tick_cnt_d    = tick_cnt_q;
      scan_pend_d   = scan_pend_q;
      rd_cnt_d      = rd_cnt_q;
      ram_addr_d    = ram_addr_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
      wr_ack_d      = 1'b0;
      wr_err_d      = wr_err_q;
      disp_addr_d   = disp_addr_q;
      disp_data_d   = disp_data_q;
      disp_valid_d  = disp_valid_q;
      scan_pend_clr = 1'b0;
      tick_active   = (state_q != S_INIT) && (state_q != S_INIT_END);

      unique case (state_q)
         S_INIT: begin
            ram_addr_d = init_cnt_q;
            ram_data_d = '0;
            ram_wren_d = 1'b1;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_LAST) begin
               state_d = S_INIT_END;
            end
         end
         S_INIT_END: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            // Writes win; a pending scan waits for the first idle cycle without wr_req.
            if (wr_req) begin
               ram_addr_d = wr_addr;
               ram_data_d = wr_data;
               ram_wren_d = 1'b1;
               state_d    = S_WRITE;
            end else if (scan_pend_q) begin
               ram_addr_d    = scan_ptr_q;
               rd_cnt_d      = '0;
               scan_pend_clr = 1'b1;
               state_d       = S_RD_WAIT;
            end
         end
         S_WRITE: begin
`ifdef RAM_WR_VERIFY_EN
            rd_cnt_d = '0;
            state_d  = S_VERIFY;
`else
            wr_ack_d = 1'b1;
            state_d  = S_IDLE;
`endif
         end
         S_RD_WAIT: begin
            if (rd_cnt_q == RD_DONE) begin
               disp_data_d  = ram_q;
               disp_addr_d  = scan_ptr_q;
               disp_valid_d = 1'b1;
               scan_ptr_d   = scan_ptr_q + 1'b1;
               state_d      = S_IDLE;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end
         S_VERIFY: begin
`ifdef RAM_WR_VERIFY_EN
            // ram_addr still holds the written address, so dropping wren turns it into a read.
            if (rd_cnt_q == VFY_DONE) begin
               wr_ack_d = 1'b1;
               if (ram_q != ram_data_q) begin
                  wr_err_d = 1'b1;
               end
               state_d = S_IDLE;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: begin
            state_d = S_INIT;
         end
      endcase

      if (scan_pend_clr) begin
         scan_pend_d = 1'b0;
      end
      if (!scan_en) begin
         tick_cnt_d  = '0;
         scan_pend_d = 1'b0;
      end else if (tick_active) begin
         if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d  = '0;
            scan_pend_d = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end else begin
         tick_cnt_d = '0;
      end
   end

   assign ram_addr   = ram_addr_q;
   assign ram_data   = ram_data_q;
   assign ram_wren   = ram_wren_q;
   assign wr_ack     = wr_ack_q;
   assign wr_err     = wr_err_q;
   assign disp_addr  = disp_addr_q;
   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;
   assign init_busy  = (state_q == S_INIT) || (state_q == S_INIT_END);

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb/tb_ram_scan_ctrl.sv - self-checking bench for ram_scan_ctrl with a 32x4 RAM model
// Define RAM_WR_VERIFY_EN to exercise the readback check against a bit0 stuck-at-0 RAM.
module tb_ram_scan_ctrl;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 4;
   localparam int TICK   = 8;
   localparam int RD_LAT = 1;
   localparam int DEPTH  = 32;
`ifdef RAM_WR_VERIFY_EN
   localparam int ACK_LAT = RD_LAT + 3;
   localparam int ERR_EXP = 1;
   localparam logic [3:0] STUCK_MASK = 4'hE;
`else
   localparam int ACK_LAT = 1;
   localparam int ERR_EXP = 0;
   localparam logic [3:0] STUCK_MASK = 4'hF;
`endif

   logic              CLOCK_50;
   logic              rst_n, wr_req, scan_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack, wr_err, ram_wren, disp_valid, init_busy;
   logic [ADDR_W-1:0] ram_addr, disp_addr;
   logic [DATA_W-1:0] ram_data, ram_q, disp_data;

   ram_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_CYCLES(TICK), .RD_LAT(RD_LAT)) dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .scan_en(scan_en),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
      .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .init_busy(init_busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // RAM: registered address, data RD_LAT clocks later; optional stuck bit on writes.
   logic [3:0] mem  [DEPTH];
   logic [3:0] pipe [RD_LAT];
   always @(posedge CLOCK_50) begin
      if (ram_wren) mem[ram_addr] <= ram_data & STUCK_MASK;
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_q = pipe[RD_LAT-1];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout actual=none expected=event time=%0t", name, $time);
   endtask

   // Timeline model: each operation books the cycles of its visible events.
   int         cyc = 0;
   bit         model_ok = 0;
   int         m_init, m_ready_at, m_ack_at, m_cap_at, m_err_at, m_tick, m_ptr;
   bit         m_pend, m_err_val;
   logic [3:0] shadow [DEPTH];
   logic [3:0] m_cap_data;
   logic [4:0] m_cap_addr;
   logic       e_wren, e_ack, e_err, e_dvalid, e_busy;
   logic [4:0] e_addr, e_daddr;
   logic [3:0] e_data, e_ddata;

   always @(posedge CLOCK_50) begin
      cyc++;
      model_ok = 1;
      if (!rst_n) begin
         m_init = 0; m_ready_at = 0; m_ack_at = -1; m_cap_at = -1; m_err_at = -1;
         m_tick = 0; m_ptr = 0; m_pend = 0; m_err_val = 0;
         e_wren = 0; e_addr = 0; e_data = 0; e_ack = 0; e_err = 0;
         e_daddr = 0; e_ddata = 0; e_dvalid = 0; e_busy = 1;
      end else begin
         e_ack = 0;
         if (m_init < DEPTH) begin
            e_wren = 1; e_addr = 5'(m_init); e_data = 0;
            shadow[m_init] = 0;
            m_init++;
         end else if (m_init == DEPTH) begin
            e_wren = 0; e_busy = 0;
            m_init++;
         end else begin
            e_wren = 0;
            if (cyc == m_ack_at) e_ack = 1;
            if (cyc == m_err_at && m_err_val) e_err = 1;
            if (cyc == m_cap_at) begin
               e_daddr = m_cap_addr; e_ddata = m_cap_data; e_dvalid = 1;
               m_ptr = (m_ptr + 1) % DEPTH;
            end
            if (cyc >= m_ready_at) begin
               if (wr_req) begin
                  e_wren = 1; e_addr = wr_addr; e_data = wr_data;
                  shadow[wr_addr] = wr_data & STUCK_MASK;
                  m_ack_at = cyc + ACK_LAT;
                  m_ready_at = cyc + ACK_LAT + 1;
                  if (ERR_EXP == 1) begin
                     m_err_at = cyc + ACK_LAT;
                     m_err_val = ((wr_data & STUCK_MASK) != wr_data);
                  end
               end else if (m_pend) begin
                  m_pend = 0;
                  m_cap_at = cyc + RD_LAT + 1;
                  m_cap_addr = 5'(m_ptr);
                  m_cap_data = shadow[m_ptr];
                  m_ready_at = cyc + RD_LAT + 2;
               end
            end
            if (!scan_en) begin
               m_tick = 0; m_pend = 0;
            end else if (m_tick == TICK - 1) begin
               m_tick = 0; m_pend = 1;
            end else begin
               m_tick++;
            end
         end
      end
   end

   always @(negedge CLOCK_50) begin
      if (model_ok) begin
         chk("ram_wren", ram_wren, e_wren);
         if (e_wren) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_data", ram_data, e_data);
         end
         chk("wr_ack", wr_ack, e_ack);
         chk("wr_err", wr_err, e_err);
         chk("init_busy", init_busy, e_busy);
         chk("disp_valid", disp_valid, e_dvalid);
         chk("disp_addr", disp_addr, e_daddr);
         chk("disp_data", disp_data, e_ddata);
      end
   end

   task automatic count_busy(output int n);
      n = init_busy ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLOCK_50);
         if (init_busy) n++;
         else break;
      end
   endtask

   task automatic wait_capture(output bit ok);
      logic [4:0] prev;
      logic       pv;
      prev = disp_addr; pv = disp_valid; ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLOCK_50);
         if (disp_valid != pv || disp_addr != prev) begin
            ok = 1;
            break;
         end
      end
      if (!ok) tmo("capture");
   endtask

   task automatic wait_addr(input logic [4:0] a);
      bit ok;
      for (int i = 0; i < 40; i++) begin
         wait_capture(ok);
         if (!ok || disp_addr == a) break;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (cyc + 1 >= m_ready_at) return;
         @(negedge CLOCK_50);
      end
      tmo("idle");
   endtask

   task automatic single_write(input logic [4:0] a, input logic [3:0] d, input string tag);
      int  e0;
      bit  found;
      wait_idle();
      wr_addr = a; wr_data = d; wr_req = 1;
      @(negedge CLOCK_50);
      wr_req = 0;
      chk({tag, "_wren"}, ram_wren, 1);
      chk({tag, "_addr"}, ram_addr, a);
      chk({tag, "_data"}, ram_data, d);
      e0 = cyc; found = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLOCK_50);
         if (wr_ack) begin
            found = 1;
            break;
         end
      end
      if (found) chk({tag, "_ack_latency"}, cyc - e0, ACK_LAT);
      else tmo({tag, "_ack"});
   endtask

   initial begin
      int n, rel, t0, changes;
      bit ok;
      logic [4:0] prev;
      rst_n = 0; wr_req = 0; wr_addr = 0; wr_data = 0; scan_en = 1;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_init_busy", init_busy, 1);
      chk("rst_disp_valid", disp_valid, 0);
      rst_n = 1;
      rel = cyc;
      count_busy(n);
      chk("init_busy_cycles", n, 33);

      wait_capture(ok);
      chk("first_capture_edge", cyc - rel, 44);
      chk("first_capture_addr", disp_addr, 0);
      chk("first_capture_data", disp_data, 0);
      t0 = cyc;
      wait_capture(ok);
      chk("scan_period", cyc - t0, TICK);
      chk("second_capture_addr", disp_addr, 1);

      single_write(5'd5, 4'hA, "wr5");
      wait_addr(5'd5);
      chk("scan_after_write", disp_data, 4'hA);

      wait_capture(ok);
      wr_addr = 5'd20; wr_data = 4'h2; wr_req = 1;
      changes = 0; prev = disp_addr;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (disp_addr != prev) changes++;
         prev = disp_addr;
      end
      chk("hold_no_scan", changes, 0);
      wr_req = 0;
      t0 = cyc;
      wait_capture(ok);
      chk("deferred_scan_latency_ok", (cyc - t0) <= RD_LAT + 3, 1);

      scan_en = 0;
      repeat (25) @(negedge CLOCK_50);
      scan_en = 1;

      single_write(5'd9, 4'h3, "wr9");
      chk("wr_err_at_ack", wr_err, ERR_EXP);
      repeat (10) @(negedge CLOCK_50);
      chk("wr_err_sticky", wr_err, ERR_EXP);

      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLOCK_50);
         if (m_cap_at == cyc + 1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) tmo("rd_wait");
      rst_n = 0;
      @(negedge CLOCK_50);
      chk("rdwait_rst_busy", init_busy, 1);
      chk("rdwait_rst_valid", disp_valid, 0);
      chk("rdwait_rst_wren", ram_wren, 0);
      chk("rdwait_rst_err", wr_err, 0);
      rst_n = 1;

      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK_50);
         if (m_init == 17) begin
            ok = 1;
            break;
         end
      end
      if (!ok) tmo("init17");
      chk("init17_addr", ram_addr, 16);
      rst_n = 0;
      @(negedge CLOCK_50);
      chk("init_rst_busy", init_busy, 1);
      chk("init_rst_wren", ram_wren, 0);
      chk("init_rst_addr", ram_addr, 0);
      rst_n = 1;
      count_busy(n);
      chk("reinit_busy_cycles", n, 33);
      wait_addr(5'd5);
      chk("reinit_addr5_zero", disp_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
